// File: rtl/iir_ch_scheduler.sv
// iir_ch_scheduler
//   Shares one first-order IIR datapath (y = b0*x + b1*x_prev + a1*y_prev)
//   among NCH sample channels. Channels are granted round-robin. Each channel
//   has its own coefficient bank and its own filter state.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req_valid  per-channel sample valid
//   req_x      per-channel signed 4-bit sample; channel i at [4i+3:4i]
//   req_ready  per-channel accept (one-hot or zero)
//   cfg_we     coefficient write strobe for channel cfg_ch
//   cfg_clr    clear x_prev/y_prev of channel cfg_ch
//   cfg_ch     target channel for cfg_we/cfg_clr (>= NCH is ignored)
//   cfg_b0/b1/a1  signed 4-bit coefficients
//   out_valid  one-cycle result pulse
//   out_ch     channel of the result
//   out_y      signed 8-bit result (wrapped, no saturation)
//
// state | meaning
// IDLE  | search for a requester starting at the pointer; latch on grant
// CALC  | compute the latched sample; publish result and update filter state
module iir_ch_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        req_valid,
  input  logic [4*NCH-1:0]      req_x,
  output logic [NCH-1:0]        req_ready,
  input  logic                  cfg_we,
  input  logic                  cfg_clr,
  input  logic [CW-1:0]         cfg_ch,
  input  logic signed [3:0]     cfg_b0,
  input  logic signed [3:0]     cfg_b1,
  input  logic signed [3:0]     cfg_a1,
  output logic                  out_valid,
  output logic [CW-1:0]         out_ch,
  output logic signed [7:0]     out_y
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] ptr;

  logic signed [3:0] b0_r [NCH];
  logic signed [3:0] b1_r [NCH];
  logic signed [3:0] a1_r [NCH];
  logic signed [3:0] xp_r [NCH];
  logic signed [7:0] yp_r [NCH];

  logic [CW-1:0]     ch_l;
  logic signed [3:0] x_l, b0_l, b1_l, a1_l;

  // Grant search: rotate the request vector so the pointer sits at bit 0,
  // take the lowest set bit, then rotate the offset back.
  logic [2*NCH-1:0] req_dbl;
  logic             gnt_any;
  int               gnt_off;
  int               gnt_sum;
  logic [CW-1:0]    gnt_idx;
  logic [NCH-1:0]   gnt_oh;

  assign req_dbl = {req_valid, req_valid} >> ptr;

  always_comb begin
    gnt_any = 1'b0;
    gnt_off = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_dbl[k]) begin
        gnt_any = 1'b1;
        gnt_off = k;
      end
    end
    gnt_sum = int'(ptr) + gnt_off;
    if (gnt_sum >= NCH) gnt_sum = gnt_sum - NCH;
    gnt_idx = CW'(gnt_sum);
    for (int i = 0; i < NCH; i++) begin
      gnt_oh[i] = gnt_any && (gnt_idx == CW'(i));
    end
  end

  // Sample and coefficients of the channel being granted
  logic signed [3:0] sel_x, sel_b0, sel_b1, sel_a1;

  always_comb begin
    sel_x  = '0;
    sel_b0 = '0;
    sel_b1 = '0;
    sel_a1 = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == CW'(i)) begin
        sel_x  = req_x[4*i +: 4];
        sel_b0 = b0_r[i];
        sel_b1 = b1_r[i];
        sel_a1 = a1_r[i];
      end
    end
  end

  // Filter state of the channel in CALC
  logic signed [3:0] cur_xp;
  logic signed [7:0] cur_yp;

  always_comb begin
    cur_xp = '0;
    cur_yp = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_l == CW'(i)) begin
        cur_xp = xp_r[i];
        cur_yp = yp_r[i];
      end
    end
  end

  // Operands are sign-extended to 12 bits before multiplying; the low 12
  // bits of each product are exact for these operand ranges.
  logic signed [11:0] p_b0, p_b1, p_a1, sum;

  assign p_b0 = 12'(b0_l) * 12'(x_l);
  assign p_b1 = 12'(b1_l) * 12'(cur_xp);
  assign p_a1 = 12'(a1_l) * 12'(cur_yp);
  assign sum  = p_b0 + p_b1 + p_a1;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = CALC;
      CALC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (req_ready also forced low while reset is held)
  always_comb begin
    req_ready = '0;
    if (state == IDLE && reset_n) req_ready = gnt_oh;
  end

  // Grant latch and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr  <= '0;
      ch_l <= '0;
      x_l  <= '0;
      b0_l <= '0;
      b1_l <= '0;
      a1_l <= '0;
    end else if (state == IDLE && gnt_any) begin
      ptr  <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      ch_l <= gnt_idx;
      x_l  <= sel_x;
      b0_l <= sel_b0;
      b1_l <= sel_b1;
      a1_l <= sel_a1;
    end
  end

  // Coefficient banks and per-channel filter state; clear beats the CALC
  // write-back when both target the same channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        b0_r[i] <= '0;
        b1_r[i] <= '0;
        a1_r[i] <= '0;
        xp_r[i] <= '0;
        yp_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && cfg_ch == CW'(i)) begin
          b0_r[i] <= cfg_b0;
          b1_r[i] <= cfg_b1;
          a1_r[i] <= cfg_a1;
        end
        if (cfg_clr && cfg_ch == CW'(i)) begin
          xp_r[i] <= '0;
          yp_r[i] <= '0;
        end else if (state == CALC && ch_l == CW'(i)) begin
          xp_r[i] <= x_l;
          yp_r[i] <= sum[7:0];
        end
      end
    end
  end

  // Result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= (state == CALC);
      if (state == CALC) begin
        out_ch <= ch_l;
        out_y  <= sum[7:0];
      end
    end
  end

endmodule

// File: tb/tb_iir_ch_scheduler.sv
module tb_iir_ch_scheduler;

  localparam int NCH = 4;
  localparam int CW  = 3;

  logic               clk;
  logic               reset_n;
  logic [NCH-1:0]     req_valid;
  logic [4*NCH-1:0]   req_x;
  logic [NCH-1:0]     req_ready;
  logic               cfg_we;
  logic               cfg_clr;
  logic [CW-1:0]      cfg_ch;
  logic signed [3:0]  cfg_b0, cfg_b1, cfg_a1;
  logic               out_valid;
  logic [CW-1:0]      out_ch;
  logic signed [7:0]  out_y;

  iir_ch_scheduler #(.NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .cfg_we    (cfg_we),
    .cfg_clr   (cfg_clr),
    .cfg_ch    (cfg_ch),
    .cfg_b0    (cfg_b0),
    .cfg_b1    (cfg_b1),
    .cfg_a1    (cfg_a1),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_y     (out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int ch;
    int y;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    int ch;
    bit cfg;
    bit clr;
    int b0;
    int b1;
    int a1;
    int x;
    int exp_y;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int y);
    exp_t e;
    e.ch = ch;
    e.y  = y;
    sb_q.push_back(e);
  endtask

  // Result monitor: every out_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", int'(out_valid), 0);
      end else begin
        e = sb_q.pop_front();
        check("out_ch", int'(out_ch), e.ch);
        check("out_y", int'(out_y), e.y);
      end
    end
  end

  task automatic do_cfg(input int ch, input bit we, input bit clr,
                        input int b0, input int b1, input int a1);
    cfg_ch  = CW'(ch);
    cfg_b0  = 4'(b0);
    cfg_b1  = 4'(b1);
    cfg_a1  = 4'(a1);
    cfg_we  = we;
    cfg_clr = clr;
    @(negedge clk);
    cfg_we  = 1'b0;
    cfg_clr = 1'b0;
  endtask

  // Raise valid for ch and wait (bounded) for its grant; returns at the
  // negedge just before the granting edge with valid still high.
  task automatic wait_grant(input int ch, input int x, output bit ok);
    ok = 1'b0;
    req_valid[ch]     = 1'b1;
    req_x[4*ch +: 4]  = 4'(x);
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (req_ready[ch]) ok = 1'b1;
      else @(negedge clk);
    end
    check("grant_seen", int'(ok), 1);
  endtask

  task automatic send(input int ch, input int x, input int exp_y);
    bit ok;
    wait_grant(ch, x, ok);
    if (ok) push_exp(ch, exp_y);
    @(negedge clk);
    req_valid[ch] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb_q.size() != 0; n++) @(negedge clk);
    check("drain", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Holds req_valid = vmask for ncyc cycles; grants must follow 'order'
  // on even cycles and req_ready must be zero on odd (CALC) cycles.
  task automatic rr_run(input logic [NCH-1:0] vmask, input int order[],
                        input int ncyc, input string nm);
    logic [NCH-1:0] exp_rdy;
    req_valid = vmask;
    for (int c = 0; c < ncyc; c++) begin
      #2;
      exp_rdy = '0;
      if (c % 2 == 0) exp_rdy[order[c/2]] = 1'b1;
      check(nm, int'(req_ready), int'(exp_rdy));
      if (c % 2 == 0) push_exp(order[c/2], 0);
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    bit ok;
    int rr_order[];
    reset_n   = 1'b0;
    req_valid = '0;
    req_x     = '0;
    cfg_we    = 1'b0;
    cfg_clr   = 1'b0;
    cfg_ch    = '0;
    cfg_b0    = '0;
    cfg_b1    = '0;
    cfg_a1    = '0;

    //             ch cfg clr  b0  b1  a1   x   exp
    vecs[0]  = '{0, 1, 1,  3,  0,  4,  5,   15};
    vecs[1]  = '{0, 0, 0,  0,  0,  0,  5,   75};
    vecs[2]  = '{0, 0, 0,  0,  0,  0,  5,   59};
    vecs[3]  = '{1, 1, 1,  2, -2, -4,  5,   10};
    vecs[4]  = '{1, 0, 0,  0,  0,  0,  5,  -40};
    vecs[5]  = '{1, 0, 0,  0,  0,  0,  5,  -96};
    vecs[6]  = '{2, 1, 0,  1,  1,  0, -8,   -8};
    vecs[7]  = '{2, 0, 0,  0,  0,  0, -8,  -16};
    vecs[8]  = '{3, 1, 0, -8, -8, -8, -8,   64};
    vecs[9]  = '{3, 0, 0,  0,  0,  0, -8, -128};
    vecs[10] = '{3, 0, 0,  0,  0,  0,  7,    8};
    vecs[11] = '{2, 0, 0,  0,  0,  0,  7,   -1};

    // Reset state, with requests pending
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_y", int'(out_y), 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single-channel samples
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].cfg)
        do_cfg(vecs[i].ch, 1'b1, vecs[i].clr, vecs[i].b0, vecs[i].b1, vecs[i].a1);
      send(vecs[i].ch, vecs[i].x, vecs[i].exp_y);
    end
    drain();

    // Round-robin fairness from reset (zero coefficients -> zero results)
    do_reset();
    rr_order = '{0, 1, 2, 3, 0, 1};
    rr_run(4'b1111, rr_order, 12, "rr_ready");
    drain();

    // Skip and wrap: bring pointer to 3, then only ch0 and ch2 request
    send(2, 0, 0);
    drain();
    rr_order = '{0, 2, 0};
    rr_run(4'b0101, rr_order, 6, "skip_ready");
    drain();

    // Coefficient write while the channel is in CALC
    do_cfg(0, 1'b1, 1'b0, 1, 0, 0);
    wait_grant(0, 7, ok);
    if (ok) push_exp(0, 7);
    @(negedge clk);
    req_valid[0] = 1'b0;
    do_cfg(0, 1'b1, 1'b0, 2, 0, 0);
    send(0, 7, 14);
    drain();

    // Clear coinciding with the CALC write-back of the same channel
    do_cfg(0, 1'b1, 1'b0, 3, 0, 4);
    wait_grant(0, 5, ok);
    if (ok) push_exp(0, 71);
    @(negedge clk);
    req_valid[0] = 1'b0;
    do_cfg(0, 1'b0, 1'b1, 0, 0, 0);
    send(0, 5, 15);
    drain();

    // Reset asserted while a sample is in CALC
    wait_grant(0, 5, ok);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_y", int'(out_y), 0);
    check("midrst_out_ch", int'(out_ch), 0);
    check("midrst_req_ready", int'(req_ready), 0);
    @(negedge clk);
    check("midrst_out_valid2", int'(out_valid), 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Banks cleared by reset; out-of-range channel write is ignored
    do_cfg(4, 1'b1, 1'b0, 5, 5, 5);
    send(0, 5, 0);
    send(3, 7, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
